rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
Shares the single write port of the register file between R requesters, such as ALU writeback, load unit and CSR/move unit.
- Round-robin arbitration, with an optional lock that lets one requester own the port for back-to-back writes.
- Registers the winning write and drives the register file write enable, destination and data directly.
- Sits between the execution units and the register file write port.

Parameters:
N, 32, data width in bits; matches the register file word width.
W, 32, number of registers; destination index width is $clog2(W).
R, 4, number of requesters (R >= 2); requester index width is $clog2(R).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
req  input  R  per-requester write request; held until granted
req_lock  input  R  per-requester lock; sampled only together with req
req_dst  input  R*$clog2(W)  destination index; slice i belongs to requester i
req_data  input  R*N  write data; slice i belongs to requester i
hold  input  1  freeze: no grants while 1
gnt  output  R  one-hot, combinational; gnt[i]=1 means slice i is captured at this clock edge
rf_we  output  1  registered write enable to the register file
rf_dst  output  $clog2(W)  registered destination to the register file
rf_din  output  N  registered write data to the register file
grant_id  output  $clog2(R)  registered index of the requester driving the current rf_* write
locked  output  1  registered; 1 while in state LOCKED

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_dst=0, rf_din=0, grant_id=0, locked=0.
  - Round-robin pointer ptr=0; state=ARB.
  - gnt forced to all-zero while rst=0.
- Latency: a grant in cycle t gives rf_we=1 with the captured dst/data in cycle t+1. rf_we is a single-cycle pulse per grant.
- If no grant occurs in cycle t: rf_we=0 in t+1; rf_dst and rf_din hold their previous values.
- Handshake: a requester keeps req, req_dst and req_data stable until it sees gnt[i]=1. At most one gnt bit is set per cycle.
- hold=1: gnt=0; state, ptr and owner unchanged; rf_we=0 in the next cycle.
- State ARB:
  - Winner is the first i with req[i]=1, searching from ptr upward with wrap (ptr, ptr+1, ..., R-1, 0, ...).
  - On a grant: ptr <= (winner+1) mod R.
  - If req_lock[winner]=1: owner <= winner and state <= LOCKED.
  - No requests: no grant; ptr unchanged.
- State LOCKED:
  - Only the owner is eligible; all other requests wait, and no grant goes to them even if the owner is idle that cycle.
  - owner req=1 and lock=1: grant, stay LOCKED.
  - owner req=1 and lock=0: grant (final write), go to ARB, ptr <= (owner+1) mod R.
  - owner req=0: no grant, go to ARB the same edge. Others become eligible from the following cycle.
- Arithmetic/width: ptr wraps modulo R; for non-power-of-two R, the increment from R-1 returns to 0 explicitly.
- Reset mid-operation: an in-flight registered write is discarded (rf_we=0 immediately); LOCKED ownership is lost.

Optional Feature:
Macro RF_ZERO_REG_PROTECT_EN.
- Defined: a request with req_dst=0 is still granted normally (gnt asserted, ptr/state update as usual), but rf_we stays 0 for that write. grant_id updates; rf_dst and rf_din keep their previous values. This keeps register 0 hardwired to zero.
- Undefined: dst=0 writes pass through like any other destination.

Test Plan:
1. Reset with rst=0 mid-stream while rf_we=1 → rf_we, rf_dst, rf_din, grant_id, locked all 0 immediately; after release, first grant with req=4'b1111 goes to requester 0.
2. req=4'b1111 held, each requester dropping req after its grant, ptr starting at 0 → grants in order 0,1,2,3 over four cycles. rf_we=1 in cycles 2–5, with rf_dst/rf_din matching each slice one cycle after its gnt.
3. Requester 2 holds req with req_lock=1 for 3 cycles while requesters 0 and 1 also request → three consecutive grants to 2 with locked=1. Requester 2 then drops lock with req=1 → fourth grant to 2, then ARB with ptr=3, so next grant goes to 0.
4. Locked owner 1 drops req (others requesting) → one cycle with gnt=0 and rf_we=0 next cycle; the following cycle a round-robin grant starting from ptr=2.
5. hold=1 for 2 cycles with req=4'b0101 → gnt=0 and rf_we=0 throughout. After hold=0, grant goes to requester 0 (ptr=0) with its data on rf_din one cycle later.
6. With RF_ZERO_REG_PROTECT_EN defined, requester 3 writes dst=0, data=32'hDEADBEEF → gnt[3]=1, rf_we stays 0, grant_id=3. Without the macro, rf_we=1, rf_dst=0, rf_din=32'hDEADBEEF.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port among R
// requesters. Grants rotate round-robin. A requester that asserts req_lock
// with its request keeps the port for back-to-back writes. The winning
// write is registered and drives the register file write port one cycle
// after its grant.
//
// Optional build macro: RF_ZERO_REG_PROTECT_EN. When it is defined, a
// granted write to destination 0 never raises rf_we. This keeps register 0
// hardwired to zero.
module rf_write_arbiter #(
  parameter int N = 32,
  parameter int W = 32,
  parameter int R = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [R-1:0]              req,
  input  logic [R-1:0]              req_lock,
  input  logic [R*$clog2(W)-1:0]    req_dst,
  input  logic [R*N-1:0]            req_data,
  input  logic                      hold,
  output logic [R-1:0]              gnt,
  output logic                      rf_we,
  output logic [$clog2(W)-1:0]      rf_dst,
  output logic [N-1:0]              rf_din,
  output logic [$clog2(R)-1:0]      grant_id,
  output logic                      locked
);

  localparam int DW = $clog2(W);
  localparam int RW = $clog2(R);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   owner_q, owner_d;
  logic            rf_we_q;
  logic [DW-1:0]   rf_dst_q;
  logic [N-1:0]    rf_din_q;
  logic [RW-1:0]   grant_id_q;

  logic            found;
  logic [RW-1:0]   win;
  logic [RW-1:0]   idx;
  logic            gnt_vld;
  logic [RW-1:0]   sel;
  logic [DW-1:0]   sel_dst;
  logic [N-1:0]    sel_data;
  logic            wr_en;

  // Modulo-R increment. The wrap from R-1 to 0 is explicit so that a
  // non-power-of-two R also wraps correctly.
  function automatic logic [RW-1:0] inc_idx(input logic [RW-1:0] x);
    if (x == RW'(R - 1)) return '0;
    else                 return x + RW'(1);
  endfunction

  // Round-robin search: first requester at or after ptr, with wrap-around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int k = 0; k < R; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = inc_idx(idx);
    end
  end

  // Next-state logic and grant decode for the ARB/LOCKED controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_vld = 1'b0;
    sel     = win;
    if (rst && !hold) begin
      case (state_q)
        ARB: begin
          if (found) begin
            gnt_vld = 1'b1;
            sel     = win;
            ptr_d   = inc_idx(win);
            if (req_lock[win]) begin
              owner_d = win;
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          // Only the owner is eligible. An idle owner gives up the lock
          // on the same edge, so others compete from the next cycle.
          sel = owner_q;
          if (req[owner_q]) begin
            gnt_vld = 1'b1;
            ptr_d   = inc_idx(owner_q);
            if (!req_lock[owner_q]) state_d = ARB;
          end else begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
    gnt      = gnt_vld ? (R'(1) << sel) : '0;
    sel_dst  = req_dst[sel*DW +: DW];
    sel_data = req_data[sel*N +: N];
`ifdef RF_ZERO_REG_PROTECT_EN
    wr_en    = gnt_vld && (sel_dst != '0);
`else
    wr_en    = gnt_vld;
`endif
  end

  // Controller state, pointer and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_dst_q   <= '0;
      rf_din_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_dst_q <= sel_dst;
        rf_din_q <= sel_data;
      end
      if (gnt_vld) grant_id_q <= sel;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_dst   = rf_dst_q;
  assign rf_din   = rf_din_q;
  assign grant_id = grant_id_q;
  assign locked   = (state_q == LOCKED);

endmodule
